// File: rtl/axil_reg_wr_q.sv
`default_nettype none
// ============================================================================
//  Module   : axil_reg_wr_q
//  Purpose  : Queued AXI-Lite write-to-register bridge. Independent AW/W
//             FIFOs, one issue engine with wait/ack/timeout handling, and a
//             B FIFO that returns responses in issue order.
//  Revision : 1.0  initial release
// ============================================================================

// Pointer-with-wrap-bit FIFO shared by the AW, W and B queues.
module axil_reg_wr_q_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0] PTR_ONE = {{IW{1'b0}}, 1'b1};

  logic [IW:0]      wr_ptr_q;
  logic [IW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[IW] != rd_ptr_q[IW]) &&
                   (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[IW-1:0]];

  // Pointer update; callers only push when not full and pop when not empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[IW-1:0]] <= data_i;
  end
endmodule

module axil_reg_wr_q #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 40,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int AW_DEPTH       = 4,
  parameter int W_DEPTH        = 4,
  parameter int B_DEPTH        = 4,
  parameter int TIMEOUT        = 4,
  parameter int ERR_ON_TIMEOUT = 1,
  parameter int ERR_CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_WIDTH-1:0]    s_axil_awaddr,
  input  logic [2:0]               s_axil_awprot,
  input  logic                     s_axil_awvalid,
  output logic                     s_axil_awready,
  input  logic [DATA_WIDTH-1:0]    s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]    s_axil_wstrb,
  input  logic                     s_axil_wvalid,
  output logic                     s_axil_wready,
  output logic [1:0]               s_axil_bresp,
  output logic                     s_axil_bvalid,
  input  logic                     s_axil_bready,
  output logic [ADDR_WIDTH-1:0]    reg_wr_addr,
  output logic [DATA_WIDTH-1:0]    reg_wr_data,
  output logic [STRB_WIDTH-1:0]    reg_wr_strb,
  output logic                     reg_wr_en,
  input  logic                     reg_wr_wait,
  input  logic                     reg_wr_ack,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);
  localparam int                   WW       = DATA_WIDTH + STRB_WIDTH;
  localparam int                   TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam bit                   TO_EN    = (TIMEOUT != 0);
  localparam logic [TMR_W-1:0]     TMR_INIT = TO_EN ? TMR_W'(TIMEOUT - 1) : '0;
  localparam logic [TMR_W-1:0]     TMR_ONE  = TMR_W'(1);
  localparam logic [1:0]           TO_RESP  = (ERR_ON_TIMEOUT != 0) ? 2'b10 : 2'b00;
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = ERR_CNT_WIDTH'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  state_t                  state_q;
  logic [TMR_W-1:0]        timer_q;
  logic [ERR_CNT_WIDTH-1:0] err_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [STRB_WIDTH-1:0]   strb_q;
  logic                    en_q;

  logic                    aw_full, aw_empty, w_full, w_empty, b_full, b_empty;
  logic [ADDR_WIDTH-1:0]   aw_head;
  logic [WW-1:0]           w_head;
  logic [1:0]              b_head;
  logic                    start, ack_done, to_done, done;
  logic [1:0]              b_resp_in;
  logic                    w_unused;

  // Protection bits carry no meaning for the register file.
  assign w_unused = ^s_axil_awprot;

  assign s_axil_awready = !aw_full;
  assign s_axil_wready  = !w_full;
  assign s_axil_bvalid  = !b_empty;
  assign s_axil_bresp   = b_head;

  // A write starts only when both halves are queued and a B slot is free,
  // so the completion push can never meet a full B FIFO.
  assign start     = (state_q == S_IDLE) && !aw_empty && !w_empty && !b_full;
  assign ack_done  = (state_q == S_ISSUE) && reg_wr_ack;
  assign to_done   = (state_q == S_ISSUE) && !reg_wr_ack && TO_EN && (timer_q == '0);
  assign done      = ack_done || to_done;
  assign b_resp_in = ack_done ? 2'b00 : TO_RESP;

  axil_reg_wr_q_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(AW_DEPTH)) u_aw_fifo (
    .clk(clk), .rst(rst),
    .push_i(s_axil_awvalid && !aw_full), .data_i(s_axil_awaddr),
    .pop_i(done), .data_o(aw_head), .full_o(aw_full), .empty_o(aw_empty)
  );

  axil_reg_wr_q_fifo #(.WIDTH(WW), .DEPTH(W_DEPTH)) u_w_fifo (
    .clk(clk), .rst(rst),
    .push_i(s_axil_wvalid && !w_full), .data_i({s_axil_wstrb, s_axil_wdata}),
    .pop_i(done), .data_o(w_head), .full_o(w_full), .empty_o(w_empty)
  );

  axil_reg_wr_q_fifo #(.WIDTH(2), .DEPTH(B_DEPTH)) u_b_fifo (
    .clk(clk), .rst(rst),
    .push_i(done), .data_i(b_resp_in),
    .pop_i(s_axil_bvalid && s_axil_bready), .data_o(b_head),
    .full_o(b_full), .empty_o(b_empty)
  );

  // Issue engine: latch the head write, hold it until ack or timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      err_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_ISSUE;
            addr_q  <= aw_head;
            data_q  <= w_head[DATA_WIDTH-1:0];
            strb_q  <= w_head[WW-1:DATA_WIDTH];
            en_q    <= 1'b1;
            timer_q <= TMR_INIT;
          end
        end
        S_ISSUE: begin
          if (done) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            if (to_done && (err_q != '1)) err_q <= err_q + ERR_ONE;
          end else if (!reg_wr_wait && (timer_q != '0)) begin
            timer_q <= timer_q - TMR_ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          en_q    <= 1'b0;
        end
      endcase
    end
  end

  assign reg_wr_addr = addr_q;
  assign reg_wr_data = data_q;
  assign reg_wr_strb = strb_q;
  assign reg_wr_en   = en_q;
  assign err_count   = err_q;
endmodule
`default_nettype wire
